if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of IF_ID_Stage.
- Owns the PC and issues requests to instruction memory over a valid/ready request channel with an in-order, variable-latency response.
- Buffers returned instructions in a small FIFO and presents instruction / pc_plus_4 to the IF/ID register under a valid/ready handshake.
- Handles stall (downstream not ready) and redirect (branch/jump from EX), discarding wrong-path responses still in flight.

---
 rtl/if_pkg.sv | 27 ++
 rtl/if_fetch_fifo.sv | 78 +++++++
 rtl/if_fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (IDLE, RUN, DRAIN)
//   fetch_entry_t : {pc, instr} pair stored in the fetch FIFOs
//   INSTR_BYTES   : PC increment per instruction
//   NOP_INSTR     : canonical RV32 nop (addi x0, x0, 0)
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  // Fetch addresses are always word aligned; low bits are simply dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: synchronous FIFO of fetch_entry_t.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write wdata_i (ignored when full and not popping)
//   pop_i        : drop head entry (ignored when empty)
//   flush_i      : discard all entries (wins over push/pop)
//   rdata_o      : head entry (undefined when empty)
//   count_o      : number of stored entries
//   empty_o, full_o : occupancy flags
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     wdata_i,
  output fetch_entry_t     rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observable through a non-empty head.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage feeding IF/ID.
// Owns the PC, issues word-aligned requests over a valid/ready channel,
// matches in-order responses to their PCs, buffers {pc, instr} and presents
// them downstream under valid/ready. Redirects flush everything and discard
// wrong-path responses still in flight.
//   clk, rst             : clock, synchronous active-high reset
//   imem_req_valid/ready : request handshake, imem_req_addr = fetch PC
//   imem_rsp_valid/data  : in-order response, one per accepted request
//   redirect_valid/pc    : taken branch/jump from EX (pc[1:0] ignored)
//   if_valid/if_ready    : handshake to IF/ID
//   instruction_out_if, pc_out_if, pc_plus_4_out_if : head entry, 0 when empty
// Optional (define IF_PERF_CNT_EN):
//   perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt : pop / stall / discard counters
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] instruction_out_if,
  output logic [31:0] pc_plus_4_out_if,
  output logic [31:0] pc_out_if
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             req_fire, live_rsp, drop_rsp, pop;
  logic [CNT_W:0]   inflight;

  fetch_entry_t     buf_head, buf_wdata, pcq_head, pcq_wdata;
  logic [CNT_W-1:0] buf_count, pcq_count;
  logic             buf_empty, buf_full, pcq_empty, pcq_full;
  logic             unused_sig;

  assign unused_sig = ^{pcq_count, pcq_empty, pcq_full, buf_full, pcq_head.instr};

  // Credits: requests in flight plus buffered entries never exceed FIFO_DEPTH,
  // so a live response always finds room in the buffer.
  assign inflight = {1'b0, outst_q} + {1'b0, buf_count};

  always_comb begin
    imem_req_valid = (state_q == RUN) && !redirect_valid
                     && (inflight < (CNT_W + 1)'(FIFO_DEPTH));
    req_fire = imem_req_valid && imem_req_ready;
    // A response coinciding with a redirect belongs to the old path too.
    live_rsp = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    drop_rsp = imem_rsp_valid && !live_rsp;
    pop      = if_valid && if_ready;

    outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    pc_d    = req_fire ? pc_q + INSTR_BYTES : pc_q;
    drop_d  = (imem_rsp_valid && (drop_q != '0)) ? drop_q - 1'b1 : drop_q;

    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     state_d = RUN;
      DRAIN:   if (drop_d == '0) state_d = RUN;
      default: state_d = IDLE;
    endcase

    // No request fires under redirect, so outst_d already excludes any
    // response landing this cycle: exactly the remaining wrong-path count.
    if (redirect_valid) begin
      pc_d    = align_pc(redirect_pc);
      drop_d  = outst_d;
      state_d = (outst_d != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  assign imem_req_addr = pc_q;

  always_comb begin
    pcq_wdata       = '0;
    pcq_wdata.pc    = pc_q;
    buf_wdata.pc    = pcq_head.pc;
    buf_wdata.instr = imem_rsp_data;
  end

  // PC queue: PCs of requests awaiting a live response, in issue order.
  if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (req_fire),
    .pop_i   (live_rsp),
    .flush_i (redirect_valid),
    .wdata_i (pcq_wdata),
    .rdata_o (pcq_head),
    .count_o (pcq_count),
    .empty_o (pcq_empty),
    .full_o  (pcq_full)
  );

  // Instruction buffer presented to IF/ID.
  if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_instr_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (live_rsp),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i (buf_wdata),
    .rdata_o (buf_head),
    .count_o (buf_count),
    .empty_o (buf_empty),
    .full_o  (buf_full)
  );

  assign if_valid           = !buf_empty;
  assign instruction_out_if = if_valid ? buf_head.instr : '0;
  assign pc_out_if          = if_valid ? buf_head.pc : '0;
  assign pc_plus_4_out_if   = if_valid ? buf_head.pc + INSTR_BYTES : '0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pop)                  fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (if_valid && !if_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (drop_rsp)             flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] instruction_out_if, pc_plus_4_out_if, pc_out_if;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  if_fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_rsp_valid     (imem_rsp_valid),
    .imem_rsp_data      (imem_rsp_data),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .if_ready           (if_ready),
    .if_valid           (if_valid),
    .instruction_out_if (instruction_out_if),
    .pc_plus_4_out_if   (pc_plus_4_out_if),
    .pc_out_if          (pc_out_if)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt     (perf_fetch_cnt),
    .perf_stall_cnt     (perf_stall_cnt),
    .perf_flush_cnt     (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  // Program image: test-plan words at 0/4/8, hashed words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0040_0093;
      32'h8:   return 32'h0020_8133;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endcase
  endfunction

  // ---------------- reference model: expected in-order fetch stream -------
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] exp_next;

  task automatic exp_fill();
    while (exp_q.size() < 32) begin
      exp_q.push_back('{exp_next, mem_word(exp_next)});
      exp_next = exp_next + 32'd4;
    end
  endtask

  task automatic exp_restart(input logic [31:0] target);
    exp_q.delete();
    exp_next = {target[31:2], 2'b00};
    exp_fill();
  endtask

  // Advance one cycle; control-flow changes seen at the edge restart the stream.
  task automatic tick();
    @(posedge clk);
    if (rst) exp_restart(RST_PC);
    else begin
      if (redirect_valid) exp_restart(redirect_pc);
      exp_fill();
    end
    @(negedge clk);
  endtask

  // ---------------- memory model -------------------------------------------
  typedef struct { logic [31:0] addr; int unsigned due; int unsigned epoch; } mreq_t;
  mreq_t       pend[$];
  int unsigned cyc = 0, epoch = 0;
  int unsigned lat_min = 1, lat_max = 1, rdy_pct = 100, rsp_pct = 100;
  int          reqs_acc = 0, mdl_flush = 0;

  function automatic int old_pending();
    int n = 0;
    foreach (pend[i]) if (pend[i].epoch != epoch) n++;
    return n;
  endfunction

  initial begin
    mreq_t r;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      imem_req_ready = ($urandom_range(1, 100) <= rdy_pct);
      if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(1, 100) <= rsp_pct) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      #3;
      if (rst) begin
        pend.delete();
        epoch++;
        reqs_acc  = 0;
        mdl_flush = 0;
      end else begin
        if (imem_rsp_valid) begin
          r = pend.pop_front();
          if (r.epoch != epoch || redirect_valid) mdl_flush++;
        end
        if (imem_req_valid && imem_req_ready) begin
          pend.push_back('{imem_req_addr, cyc + $urandom_range(lat_min, lat_max), epoch});
          reqs_acc++;
          chk("credit_limit", 32'(pend.size() <= DEPTH), 32'd1);
        end
        if (redirect_valid) epoch++;
      end
    end
  end

  // ---------------- monitor / scoreboard -----------------------------------
  int          pops = 0, pops_rst = 0, stall_rst = 0;
  logic [31:0] last_pc = '0;

  initial begin
    exp_t        e;
    logic        prev_stall;
    logic [31:0] p_instr, p_pc, p_pc4;
    prev_stall = 1'b0;
    p_instr = '0; p_pc = '0; p_pc4 = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        prev_stall = 1'b0;
        pops_rst   = 0;
        stall_rst  = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 32'(if_valid), 32'd1);
          chk("stall_instr", instruction_out_if, p_instr);
          chk("stall_pc", pc_out_if, p_pc);
          chk("stall_pc4", pc_plus_4_out_if, p_pc4);
        end
        if (if_valid && if_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=%h required=none", pc_out_if);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", pc_out_if, e.pc);
            chk("sb_instr", instruction_out_if, e.instr);
            chk("sb_pc4", pc_plus_4_out_if, e.pc + 32'd4);
          end
          last_pc = pc_out_if;
          pops++;
          pops_rst++;
        end
        if (if_valid && !if_ready) stall_rst++;
        prev_stall = if_valid && !if_ready && !redirect_valid;
        p_instr = instruction_out_if;
        p_pc    = pc_out_if;
        p_pc4   = pc_plus_4_out_if;
      end
    end
  end

  // ---------------- helpers -------------------------------------------------
  task automatic wait_pops(input int n, input string name);
    int target = pops + n;
    for (int c = 0; c < 200 && pops < target; c++) tick();
    chk(name, 32'(pops >= target), 32'd1);
  endtask

  task automatic set_mem(input int unsigned lmin, input int unsigned lmax,
                         input int unsigned rdy, input int unsigned rsp);
    lat_min = lmin; lat_max = lmax; rdy_pct = rdy; rsp_pct = rsp;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
    chk({tag, "_instr"}, instruction_out_if, 32'd0);
    chk({tag, "_pc"}, pc_out_if, 32'd0);
    chk({tag, "_pc4"}, pc_plus_4_out_if, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk({tag, "_perf_fetch"}, perf_fetch_cnt, 32'd0);
    chk({tag, "_perf_stall"}, perf_stall_cnt, 32'd0);
    chk({tag, "_perf_flush"}, perf_flush_cnt, 32'd0);
`endif
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  // ---------------- stimulus -------------------------------------------------
  initial begin
    int viol, f0, n;
    logic found;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    rst            = 1'b1;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;

    // Straight-line fetch with 1-cycle memory.
    if_ready = 1'b1;
    tick();
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, RST_PC);
    wait_pops(3, "startup_pops");

    // Stall: buffer and credits fill, requests stop, outputs hold.
    if_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    #1;
    chk("stall_no_req", 32'(imem_req_valid), 32'd0);
    chk("stall_inflight", 32'(reqs_acc - pops_rst), DEPTH);
    chk("stall_held_valid", 32'(if_valid), 32'd1);
    if_ready = 1'b1;
    wait_pops(4, "stall_release_pops");

    // Redirect with two requests in flight.
    set_mem(4, 4, 100, 100);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (pend.size() == DEPTH) found = 1'b1;
      else tick();
    end
    chk("inflight2_found", 32'(found), 32'd1);
    f0 = mdl_flush;
    do_redirect(32'h0000_0100);
    viol = 0;
    for (int c = 0; c < 50 && old_pending() > 0; c++) begin
      #1;
      if (imem_req_valid) viol++;
      tick();
    end
    chk("drain_no_req", 32'(viol), 32'd0);
    chk("drain_done", 32'(old_pending()), 32'd0);
    chk("drain_flushed", 32'(mdl_flush - f0), 32'd2);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (imem_req_valid) found = 1'b1;
      else tick();
    end
    chk("redir_req_addr", imem_req_addr, 32'h0000_0100);
    wait_pops(1, "redir_first_pop");
    chk("redir_first_pc", last_pc, 32'h0000_0100);

    // Redirect coincident with a live response and a pop.
    set_mem(1, 1, 100, 100);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      #1;
      if (imem_rsp_valid && if_valid && old_pending() == 0) found = 1'b1;
      else tick();
    end
    chk("coinc_found", 32'(found), 32'd1);
    f0 = mdl_flush;
    do_redirect(32'h0000_0200);
    wait_pops(2, "coinc_pops");
    chk("coinc_flushed", 32'(mdl_flush - f0), 32'd1);

    // Address wrap.
    do_redirect(32'hFFFF_FFF8);
    wait_pops(4, "wrap_pops");

    // Random traffic with redirects, stalls and variable latency.
    set_mem(1, 5, 70, 70);
    n = pops;
    for (int c = 0; c < 1500; c++) begin
      if_ready       = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                   : $urandom;
      tick();
    end
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    chk("random_progress", 32'(pops - n > 100), 32'd1);
    tick();
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, 32'(pops_rst));
    chk("perf_stall", perf_stall_cnt, 32'(stall_rst));
    chk("perf_flush", perf_flush_cnt, 32'(mdl_flush));
`endif

    // Reset in the middle of traffic.
    for (int c = 0; c < 10; c++) begin
      if_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    rst = 1'b1;
    tick();
    check_reset_state("midrst");
    rst = 1'b0;
    if_ready = 1'b1;
    set_mem(1, 1, 100, 100);
    wait_pops(3, "post_reset_pops");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
